multicycle_computer_param: RTL and testbench

MULTICYCLE_COMPUTER_PARAM -- requirements
Module: multicycle_computer_param

---
 rtl/multicycle_pkg.sv | 51 +++++
 rtl/multicycle_computer_param_alu.sv | 61 ++++++
 rtl/multicycle_computer_param.sv | 166 ++++++++++++++++
 tb/tb_multicycle_computer_param.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared opcodes, controller state codes, flag bit indices and instruction field offsets.
// The build macro MULTICYCLE_SHIFT_EN enables the SHL/SHR opcodes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_MEM    = 4'd3,
        ST_WB     = 4'd4,
        ST_HALT   = 4'd5
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hD;
    localparam logic [3:0] OP_SHL  = 4'hE;
    localparam logic [3:0] OP_SHR  = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Offsets within the 8-bit header that sits above the DATA_W immediate
    localparam int F_RS = 0;
    localparam int F_RD = 2;
    localparam int F_OP = 4;

    function automatic logic sets_flags(input logic [3:0] op);
        logic f;
        f = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
            (op == OP_OR)  || (op == OP_XOR);
`ifdef MULTICYCLE_SHIFT_EN
        f = f || (op == OP_SHL) || (op == OP_SHR);
`endif
        return f;
    endfunction

endpackage

// File: rtl/multicycle_computer_param_alu.sv
// Combinational ALU: result and {V,C,N,Z} for the arithmetic, logic and shift opcodes.
// Shifts are only decoded when MULTICYCLE_SHIFT_EN is defined.
module mc_alu
    import multicycle_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            c;
    logic            v;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                v      = (a[DATA_W-1] == b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                c      = ~diff[DATA_W];
                v      = (a[DATA_W-1] != b[DATA_W-1]) &&
                         (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
`ifdef MULTICYCLE_SHIFT_EN
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                c      = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                c      = a[0];
            end
`endif
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/multicycle_computer_param.sv
// Multicycle 4-register accumulator computer with writable program ROM and data memory.
// MULTICYCLE_SHIFT_EN adds SHL/SHR on opcodes E/F; otherwise they behave as NOP.
module multicycle_computer_param
    import multicycle_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int PROG_DEPTH = 256,
    parameter  int DMEM_DEPTH = 16,
    localparam int PC_W       = $clog2(PROG_DEPTH),
    localparam int IW         = 8 + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [IW-1:0]     prog_data,
    output logic [DATA_W-1:0] R0_out,
    output logic [DATA_W-1:0] R1_out,
    output logic [3:0]        FLAGS,
    output logic [3:0]        state,
    output logic              halted
);

    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [IW-1:0]     rom_q  [PROG_DEPTH];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    logic              dm_we;

    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] wdat;

    assign op  = ir_q[DATA_W+F_OP +: 4];
    assign rd  = ir_q[DATA_W+F_RD +: 2];
    assign rs  = ir_q[DATA_W+F_RS +: 2];
    assign imm = ir_q[DATA_W-1:0];

    mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        rf_d    = rf_q;
        dm_we   = 1'b0;
        wdat    = alu_res;
        case (state_q)
            ST_FETCH: begin
                ir_d    = rom_q[pc_q];
                pc_d    = (pc_q == PC_W'(PROG_DEPTH-1)) ? '0 : pc_q + 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                a_d     = rf_q[rd];
                b_d     = rf_q[rs];
                state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_NOP: state_d = ST_FETCH;
                    OP_JMP: begin
                        pc_d    = PC_W'(imm);
                        state_d = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (flags_q[FLAG_Z]) pc_d = PC_W'(imm);
                        state_d = ST_FETCH;
                    end
                    OP_JC: begin
                        if (flags_q[FLAG_C]) pc_d = PC_W'(imm);
                        state_d = ST_FETCH;
                    end
                    OP_LD, OP_ST: state_d = ST_MEM;
`ifdef MULTICYCLE_SHIFT_EN
                    OP_SHL, OP_SHR: state_d = ST_WB;
`else
                    OP_SHL, OP_SHR: state_d = ST_FETCH;
`endif
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (op == OP_ST) begin
                    dm_we   = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    res_d   = dmem_q[b_q[DA_W-1:0]];
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                case (op)
                    OP_LDI:  wdat = imm;
                    OP_MOV:  wdat = b_q;
                    OP_LD:   wdat = res_q;
                    default: wdat = alu_res;
                endcase
                rf_d[rd] = wdat;
                if (sets_flags(op)) flags_d = alu_flags;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rf_q    <= rf_d;
        end
    end

    // Memories are deliberately left out of reset
    always_ff @(posedge clock) begin
        if (prog_we) rom_q[prog_addr] <= prog_data;
        if (!reset && dm_we) dmem_q[b_q[DA_W-1:0]] <= a_q;
    end

    assign R0_out = rf_q[0];
    assign R1_out = rf_q[1];
    assign FLAGS  = flags_q;
    assign state  = state_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_multicycle_computer_param.sv
// Bench for multicycle_computer_param: instruction-level model plus directed programs.
// Honors MULTICYCLE_SHIFT_EN the same way as the design build.
module tb_multicycle_computer_param;

    localparam int DW = 8;
    localparam int PD = 256;
    localparam int DD = 16;

    logic        clock;
    logic        reset;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic [7:0]  R0_out;
    logic [7:0]  R1_out;
    logic [3:0]  FLAGS;
    logic [3:0]  state;
    logic        halted;

    multicycle_computer_param #(
        .DATA_W(DW), .PROG_DEPTH(PD), .DMEM_DEPTH(DD)
    ) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .R0_out(R0_out), .R1_out(R1_out), .FLAGS(FLAGS),
        .state(state), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Architectural model
    logic [15:0] mrom [PD];
    logic [7:0]  mdm  [DD];
    logic [7:0]  mR   [4];
    logic [3:0]  mF;
    int          mpc;
    bit          mhalt;
    logic [15:0] mir;
    int          seq [$];
    int          ph;
    int          mem_seen;

    function automatic logic [15:0] ins(int op, int rd, int rs, int imm);
        return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
    endfunction

    function automatic int sx(int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_flags(int r, bit c, bit v);
        mF = {v, c, r[7], (r[7:0] == 0)};
    endtask

    task automatic apply_instr();
        int op, rd, rs, imm, a, b, r, s;
        op  = int'(mir[15:12]);
        rd  = int'(mir[11:10]);
        rs  = int'(mir[9:8]);
        imm = int'(mir[7:0]);
        a   = int'(mR[rd]);
        b   = int'(mR[rs]);
        case (op)
            1: mR[rd] = imm[7:0];
            2: begin
                r = (a + b) % 256;
                s = sx(a) + sx(b);
                mR[rd] = r[7:0];
                set_flags(r, (a + b) > 255, (s > 127) || (s < -128));
            end
            3: begin
                r = (a - b + 256) % 256;
                s = sx(a) - sx(b);
                mR[rd] = r[7:0];
                set_flags(r, a >= b, (s > 127) || (s < -128));
            end
            4: begin r = a & b; mR[rd] = r[7:0]; set_flags(r, 0, 0); end
            5: begin r = a | b; mR[rd] = r[7:0]; set_flags(r, 0, 0); end
            6: begin r = a ^ b; mR[rd] = r[7:0]; set_flags(r, 0, 0); end
            7: mR[rd] = b[7:0];
            8: mR[rd] = mdm[b % DD];
            9: mdm[b % DD] = a[7:0];
            10: mpc = imm % PD;
            11: if (mF[0]) mpc = imm % PD;
            12: if (mF[2]) mpc = imm % PD;
`ifdef MULTICYCLE_SHIFT_EN
            14: begin
                r = (a * 2) % 256;
                mR[rd] = r[7:0];
                set_flags(r, a >= 128, 0);
            end
            15: begin
                r = a / 2;
                mR[rd] = r[7:0];
                set_flags(r, a % 2 == 1, 0);
            end
`endif
            default: ;
        endcase
    endtask

    // Visible controller states for one instruction, from its latency class
    task automatic build_seq(int op);
        seq = {0, 1};
        if (op == 13) return;
        seq.push_back(2);
        case (op)
            0, 10, 11, 12: ;
            8: begin seq.push_back(3); seq.push_back(4); end
            9: seq.push_back(3);
`ifdef MULTICYCLE_SHIFT_EN
            14, 15: seq.push_back(4);
`else
            14, 15: ;
`endif
            default: seq.push_back(4);
        endcase
    endtask

    task automatic model_step(bit r, bit we, int addr, logic [15:0] d);
        if (r) begin
            for (int i = 0; i < 4; i++) mR[i] = '0;
            mF = '0; mpc = 0; mhalt = 0; mir = '0;
            seq = {0}; ph = 0;
        end else if (!mhalt) begin
            if (ph == 0) begin
                mir = mrom[mpc];
                mpc = (mpc + 1) % PD;
                build_seq(int'(mir[15:12]));
                ph = 1;
            end else if (ph == seq.size() - 1) begin
                if (mir[15:12] == 4'hD) mhalt = 1;
                else apply_instr();
                seq = {0}; ph = 0;
            end else begin
                ph++;
            end
        end
        if (we) mrom[addr] = d;
    endtask

    task automatic tick(bit r, bit we, int addr, logic [15:0] d);
        reset     = r;
        prog_we   = we;
        prog_addr = addr[7:0];
        prog_data = d;
        @(posedge clock);
        model_step(r, we, addr, d);
        #1;
        chk("state",  {28'd0, state},  mhalt ? 32'd5 : seq[ph]);
        chk("R0",     {24'd0, R0_out}, {24'd0, mR[0]});
        chk("R1",     {24'd0, R1_out}, {24'd0, mR[1]});
        chk("FLAGS",  {28'd0, FLAGS},  {28'd0, mF});
        chk("halted", {31'd0, halted}, {31'd0, mhalt});
        if (state == 4'd3) mem_seen++;
    endtask

    task automatic load(logic [15:0] p [$]);
        foreach (p[i]) tick(1, 1, i, p[i]);
        tick(1, 0, 0, '0);
        chk("rst_R0", {24'd0, R0_out}, 0);
        chk("rst_R1", {24'd0, R1_out}, 0);
        chk("rst_FLAGS", {28'd0, FLAGS}, 0);
        chk("rst_state", {28'd0, state}, 0);
        mem_seen = 0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, '0);
    endtask

    logic [15:0] p [$];

    initial begin
        seq = {0}; ph = 0; mhalt = 0; mem_seen = 0;
        for (int i = 0; i < 4; i++) mR[i] = '0;
        mF = '0; mpc = 0;
        for (int i = 0; i < PD; i++) tick(1, 1, i, 16'hD000);

        // 5+3
        p = {ins(1,0,0,5), ins(1,1,0,3), ins(2,0,1,0), ins(13,0,0,0)};
        load(p);
        run(15);
        chk("add_R0", {24'd0, R0_out}, 8);
        chk("add_R1", {24'd0, R1_out}, 3);
        chk("add_FLAGS", {28'd0, FLAGS}, 0);
        chk("add_halted", {31'd0, halted}, 1);
        run(3);
        chk("halt_stays", {31'd0, halted}, 1);

        // 0x80+0x80 overflows to zero
        p = {ins(1,0,0,8'h80), ins(1,1,0,8'h80), ins(2,0,1,0), ins(13,0,0,0)};
        load(p);
        run(16);
        chk("ovf_R0", {24'd0, R0_out}, 0);
        chk("ovf_FLAGS", {28'd0, FLAGS}, 4'b1101);

        // countdown loop
        p = {ins(1,0,0,3), ins(1,1,0,1), ins(3,0,1,0), ins(11,0,0,5),
             ins(10,0,0,2), ins(13,0,0,0)};
        load(p);
        run(45);
        chk("loop_R0", {24'd0, R0_out}, 0);
        chk("loop_FLAGS", {28'd0, FLAGS}, 4'b0101);
        chk("loop_halted", {31'd0, halted}, 1);

        // store then load back
        p = {ins(1,2,0,7), ins(1,0,0,8'h2A), ins(9,0,2,0), ins(1,0,0,0),
             ins(8,1,2,0), ins(13,0,0,0)};
        load(p);
        run(30);
        chk("ld_R1", {24'd0, R1_out}, 8'h2A);
        chk("mem_cycles", mem_seen, 2);

        // reset while in WB
        p = {ins(1,0,0,9), ins(13,0,0,0)};
        load(p);
        run(3);
        chk("wb_state", {28'd0, state}, 4);
        tick(1, 0, 0, '0);
        chk("wbrst_R0", {24'd0, R0_out}, 0);
        chk("wbrst_state", {28'd0, state}, 0);
        run(12);

        // shift left
        p = {ins(1,0,0,8'h81), ins(14,0,0,0), ins(13,0,0,0)};
        load(p);
        run(14);
`ifdef MULTICYCLE_SHIFT_EN
        chk("shl_R0", {24'd0, R0_out}, 8'h02);
        chk("shl_FLAGS", {28'd0, FLAGS}, 4'b0100);
`else
        chk("shl_R0", {24'd0, R0_out}, 8'h81);
        chk("shl_FLAGS", {28'd0, FLAGS}, 4'b0000);
`endif

        // fill data memory so random loads are defined
        p = {};
        for (int i = 0; i < DD; i++) begin
            p.push_back(ins(1, 2, 0, i));
            p.push_back(ins(1, 3, 0, $urandom_range(0, 255)));
            p.push_back(ins(9, 3, 2, 0));
        end
        p.push_back(ins(13, 0, 0, 0));
        load(p);
        run(200);
        chk("fill_halted", {31'd0, halted}, 1);

        // random programs with stray resets and live ROM writes
        for (int k = 0; k < 8; k++) begin
            p = {};
            for (int i = 0; i < 64; i++) begin
                int op;
                op = $urandom_range(0, 15);
                if (op == 13 && $urandom_range(0, 9) != 0) op = 1;
                p.push_back(ins(op, $urandom_range(0, 3), $urandom_range(0, 3),
                                $urandom_range(0, 63)));
            end
            load(p);
            for (int c = 0; c < 400; c++) begin
                bit r, we;
                r  = ($urandom_range(0, 99) == 0);
                we = ($urandom_range(0, 19) == 0);
                tick(r, we, $urandom_range(0, 63),
                     ins($urandom_range(0, 12), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 63)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
